// File: rtl/audio_pkg.sv
// Shared definitions for the audio filter path: default widths and the
// handshake FSM state encoding.
package audio_pkg;

    // Default sample width (two's-complement) and averaging depth (log2).
    localparam int unsigned DEFAULT_DATA_W    = 24;
    localparam int unsigned DEFAULT_LOG2_TAPS = 3;

    // Filter handshake states: wait for ADC pair, fold it in, push DAC pair.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/avg_channel.sv
// One channel of the moving-average filter. Each sample is pre-scaled by
// 1/TAPS and kept in a circular history; a running sum adds the newest
// scaled sample and drops the oldest, so the sum is the window average.
module avg_channel
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned LOG2_TAPS = DEFAULT_LOG2_TAPS
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              update,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] avg
);

    localparam int unsigned TAPS = 1 << LOG2_TAPS;

    logic signed [DATA_W-1:0]    hist_q [TAPS];
    logic        [LOG2_TAPS-1:0] ptr_q;
    logic signed [DATA_W-1:0]    sum_q;
    logic signed [DATA_W-1:0]    sum_d;
    logic signed [DATA_W-1:0]    scaled;

    // Scale the new sample and form the post-update sum (wraps mod 2^DATA_W).
    always_comb begin
        scaled = $signed(sample) >>> LOG2_TAPS;
        sum_d  = sum_q + scaled - hist_q[ptr_q];
    end

    // The top registers this on the update cycle, so it sees the new sum.
    assign avg = sum_d;

    // History, write pointer and running sum; cleared on reset.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                hist_q[i] <= '0;
            end
            ptr_q <= '0;
            sum_q <= '0;
        end else if (update) begin
            hist_q[ptr_q] <= scaled;
            // Pointer width equals LOG2_TAPS, so the increment wraps to 0.
            ptr_q         <= ptr_q + 1'b1;
            sum_q         <= sum_d;
        end
    end

endmodule

// File: rtl/audio_avg_filter.sv
// Stereo moving-average stage between the CODEC read and write FIFOs.
// Pops one pair when available, filters it (or passes it raw in bypass),
// and holds it on the DAC side until the CODEC can take it.
module audio_avg_filter
    import audio_pkg::*;
#(
    parameter int unsigned DATA_W    = DEFAULT_DATA_W,
    parameter int unsigned LOG2_TAPS = DEFAULT_LOG2_TAPS
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              bypass,
    input  logic              read_ready,
    input  logic [DATA_W-1:0] readdata_left,
    input  logic [DATA_W-1:0] readdata_right,
    output logic              read,
    input  logic              write_ready,
    output logic [DATA_W-1:0] writedata_left,
    output logic [DATA_W-1:0] writedata_right,
    output logic              write
);

    state_t            state_q;
    logic              bypass_q;
    logic [DATA_W-1:0] raw_left_q;
    logic [DATA_W-1:0] raw_right_q;
    logic [DATA_W-1:0] avg_left;
    logic [DATA_W-1:0] avg_right;
    logic              update;

    // History advances on every accepted pair, bypass or not, so leaving
    // bypass resumes from a correct window.
    assign update = (state_q == S_ACC);

    avg_channel #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_left (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .update   (update),
        .sample   (raw_left_q),
        .avg      (avg_left)
    );

    avg_channel #(
        .DATA_W    (DATA_W),
        .LOG2_TAPS (LOG2_TAPS)
    ) u_right (
        .CLOCK_50 (CLOCK_50),
        .reset_n  (reset_n),
        .update   (update),
        .sample   (raw_right_q),
        .avg      (avg_right)
    );

    // Pop/push strobes are qualified by the live ready flags so they can
    // only pulse while the CODEC is actually ready; states are exclusive,
    // so read and write never coincide.
    always_comb begin
        read  = (state_q == S_IDLE) && read_ready;
        write = (state_q == S_OUT)  && write_ready;
    end

    // Handshake FSM: capture raw pair, load filtered pair, wait for the DAC.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            bypass_q        <= 1'b0;
            raw_left_q      <= '0;
            raw_right_q     <= '0;
            writedata_left  <= '0;
            writedata_right <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (read_ready) begin
                        raw_left_q  <= readdata_left;
                        raw_right_q <= readdata_right;
                        bypass_q    <= bypass;
                        state_q     <= S_ACC;
                    end
                end
                S_ACC: begin
                    writedata_left  <= bypass_q ? raw_left_q  : avg_left;
                    writedata_right <= bypass_q ? raw_right_q : avg_right;
                    state_q         <= S_OUT;
                end
                S_OUT: begin
                    if (write_ready) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_avg_filter.sv
// Bench for audio_avg_filter: directed test-plan scenarios followed by
// randomized traffic, checked against a sliding-window average model.
module tb_audio_avg_filter;

    localparam int unsigned DW   = 24;
    localparam int unsigned LT   = 3;
    localparam int unsigned TAPS = 1 << LT;

    logic          CLOCK_50 = 1'b0;
    logic          reset_n = 1'b0;
    logic          bypass = 1'b0;
    logic          read_ready = 1'b0;
    logic          write_ready = 1'b0;
    logic [DW-1:0] readdata_left = '0;
    logic [DW-1:0] readdata_right = '0;
    logic          read;
    logic          write;
    logic [DW-1:0] writedata_left;
    logic [DW-1:0] writedata_right;

    int total = 0;
    int bad = 0;

    // Model: window of the last TAPS scaled samples per channel.
    int            win_l[$];
    int            win_r[$];
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;

    audio_avg_filter #(
        .DATA_W    (DW),
        .LOG2_TAPS (LT)
    ) dut (
        .CLOCK_50        (CLOCK_50),
        .reset_n         (reset_n),
        .bypass          (bypass),
        .read_ready      (read_ready),
        .readdata_left   (readdata_left),
        .readdata_right  (readdata_right),
        .read            (read),
        .write_ready     (write_ready),
        .writedata_left  (writedata_left),
        .writedata_right (writedata_right),
        .write           (write)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] window_sum(input int win[$]);
        int          s;
        logic [31:0] s_bits;
        s = 0;
        foreach (win[i]) s += win[i];
        s_bits = 32'(s);
        return s_bits[DW-1:0];
    endfunction

    task automatic model_reset();
        win_l.delete();
        win_r.delete();
        for (int i = 0; i < int'(TAPS); i++) begin
            win_l.push_back(0);
            win_r.push_back(0);
        end
    endtask

    task automatic model_push(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic byp);
        int vl;
        int vr;
        vl = int'($signed(l));
        vr = int'($signed(r));
        // Divide by TAPS rounding toward minus infinity.
        win_l.push_back(vl >>> LT);
        win_r.push_back(vr >>> LT);
        void'(win_l.pop_front());
        void'(win_r.pop_front());
        exp_l = byp ? l : window_sum(win_l);
        exp_r = byp ? r : window_sum(win_r);
    endtask

    task automatic finish_now();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    // Offer one pair; returns in S_OUT at a negedge when wr=0, or back in
    // S_IDLE at posedge+1 after the write when wr=1.
    task automatic capture(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic byp,
                           input logic wr, input logic keep_rr, input int exp_wait);
        int   n;
        logic seen;
        readdata_left  = l;
        readdata_right = r;
        bypass         = byp;
        read_ready     = 1'b1;
        write_ready    = wr;
        n    = 0;
        #1;
        seen = read;
        while (!seen && n < 16) begin
            @(posedge CLOCK_50);
            #1;
            n++;
            seen = read;
        end
        check_eq("read_seen", 32'(seen), 32'd1);
        if (!seen) finish_now();
        if (exp_wait >= 0) check_eq("read_latency", 32'(n), 32'(exp_wait));
        check_eq("write_during_read", 32'(write), 32'd0);
        model_push(l, r, byp);
        @(posedge CLOCK_50);
        #1;
        // Scramble inputs after capture: the latched pair must be used.
        read_ready     = keep_rr;
        bypass         = ~byp;
        readdata_left  = DW'($urandom);
        readdata_right = DW'($urandom);
        @(negedge CLOCK_50);
        check_eq("acc_read", 32'(read), 32'd0);
        check_eq("acc_write", 32'(write), 32'd0);
        @(negedge CLOCK_50);
        check_eq("out_left", 32'(writedata_left), 32'(exp_l));
        check_eq("out_right", 32'(writedata_right), 32'(exp_r));
        check_eq("out_write", 32'(write), 32'(wr));
        check_eq("out_read", 32'(read), 32'd0);
        if (wr) begin
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    // Hold the DAC side off for 'stall' cycles with an ADC pair pending, then
    // release it. Leaves read_ready=1 so the next read can follow at once.
    task automatic drain(input int stall);
        read_ready = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge CLOCK_50);
            check_eq("stall_write", 32'(write), 32'd0);
            check_eq("stall_read", 32'(read), 32'd0);
            check_eq("stall_left", 32'(writedata_left), 32'(exp_l));
            check_eq("stall_right", 32'(writedata_right), 32'(exp_r));
        end
        write_ready = 1'b1;
        #1;
        check_eq("release_write", 32'(write), 32'd1);
        check_eq("release_read", 32'(read), 32'd0);
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic pulse_reset();
        read_ready  = 1'b0;
        write_ready = 1'b0;
        reset_n     = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic idle_gap(input int cycles);
        read_ready = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            write_ready = 1'($urandom);
            @(negedge CLOCK_50);
            check_eq("idle_read", 32'(read), 32'd0);
            check_eq("idle_write", 32'(write), 32'd0);
            @(posedge CLOCK_50);
            #1;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          chain;
        logic [DW-1:0] dl;
        logic [DW-1:0] dr;
        logic          byp;
        int            stall;

        model_reset();
        #5;
        check_eq("rst_read", 32'(read), 32'd0);
        check_eq("rst_write", 32'(write), 32'd0);
        check_eq("rst_left", 32'(writedata_left), 32'd0);
        check_eq("rst_right", 32'(writedata_right), 32'd0);
        @(posedge CLOCK_50);
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;

        // Ramp, then wrap-around with a zero sample.
        for (int i = 1; i <= 10; i++) begin
            capture(24'h080000, 24'h080000, 1'b0, 1'b1, 1'b0, -1);
            check_eq("ramp_const", 32'(writedata_left), (i < 8 ? i : 8) * 32'h10000);
        end
        capture(24'h000000, 24'h000000, 1'b0, 1'b1, 1'b0, -1);
        check_eq("wrap_const", 32'(writedata_right), 32'h070000);

        // Negative input from a fresh history.
        pulse_reset();
        for (int i = 1; i <= 9; i++) begin
            capture(24'hF80000, 24'hF80000, 1'b0, 1'b1, 1'b0, -1);
            if (i == 1) check_eq("neg_first", 32'(writedata_left), 32'h00FF0000);
            if (i >= 8) check_eq("neg_settled", 32'(writedata_left), 32'h00F80000);
        end

        // Bypass: raw pair out, write two cycles after read.
        capture(24'h123456, 24'hEDCBAA, 1'b1, 1'b1, 1'b0, -1);
        check_eq("byp_left", 32'(writedata_left), 32'h00123456);
        check_eq("byp_right", 32'(writedata_right), 32'h00EDCBAA);

        // Back-pressure: 20 stalled cycles, then the next read right after write.
        capture(24'h0ABCDE, 24'hF00001, 1'b0, 1'b0, 1'b1, -1);
        drain(20);
        capture(24'h000100, 24'h7FFFF8, 1'b0, 1'b1, 1'b0, 0);

        // Asynchronous reset while holding a pair in S_OUT.
        capture(24'h123456, 24'h654321, 1'b1, 1'b0, 1'b0, -1);
        #2;
        write_ready = 1'b1;
        reset_n     = 1'b0;
        #1;
        check_eq("midrst_write", 32'(write), 32'd0);
        check_eq("midrst_left", 32'(writedata_left), 32'd0);
        check_eq("midrst_right", 32'(writedata_right), 32'd0);
        write_ready = 1'b0;
        @(posedge CLOCK_50);
        #1;
        reset_n = 1'b1;
        model_reset();
        capture(24'h080000, 24'h080000, 1'b0, 1'b1, 1'b0, -1);
        check_eq("postrst_const", 32'(writedata_left), 32'h010000);

        // Randomized traffic with gaps, stalls and bypass toggling.
        chain = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (!chain) idle_gap($urandom_range(0, 3));
            dl    = DW'($urandom);
            dr    = DW'($urandom);
            byp   = ($urandom_range(0, 4) == 0);
            stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0;
            if (stall == 0) begin
                capture(dl, dr, byp, 1'b1, 1'b0, chain ? 0 : -1);
                chain = 1'b0;
            end else begin
                capture(dl, dr, byp, 1'b0, 1'b1, chain ? 0 : -1);
                drain(stall);
                chain = 1'b1;
            end
        end

        finish_now();
    end

endmodule
